// File: rtl/pwm_timer_pkg.sv
// Shared constants for the multi-channel PWM timer: mode encodings, count direction and default sizing.
package pwm_timer_pkg;

   localparam int unsigned DEF_CNT_W      = 10;
   localparam int unsigned DEF_NUM_CH     = 4;
   localparam int unsigned DEF_RST_PERIOD = 999;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/pwm_multi_timer_if.sv
// Timer-to-channel bus: shadow load strobe, boundary commit strobe and the shared counter value.
interface pwm_multi_timer_if #(
   parameter int unsigned CNT_W = pwm_timer_pkg::DEF_CNT_W
);
   logic             load;
   logic             commit;
   logic [CNT_W-1:0] counter;

   modport master (output load, commit, counter);
   modport slave  (input  load, commit, counter);
endinterface

// File: rtl/pwm_compare_ch.sv
// One PWM channel: shadow/active duty pair plus the counter comparator.
module pwm_compare_ch #(
   parameter int unsigned CNT_W = pwm_timer_pkg::DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   pwm_multi_timer_if.slave bus,
   input  logic [CNT_W-1:0] duty_in,
   output logic             pwm_c
);

   logic [CNT_W-1:0] shd_duty_q;
   logic [CNT_W-1:0] act_duty_q;

   // On a coincident load and commit the active duty takes the old shadow.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         shd_duty_q <= '0;
         act_duty_q <= '0;
      end else begin
         if (bus.load)   shd_duty_q <= duty_in;
         if (bus.commit) act_duty_q <= shd_duty_q;
      end
   end

   assign pwm_c = (bus.counter < act_duty_q);

endmodule

// File: rtl/pwm_multi_timer.sv
// Multi-channel PWM timer with edge- and center-aligned counting and boundary-synchronous reloads.
module pwm_multi_timer
   import pwm_timer_pkg::*;
#(
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned NUM_CH     = DEF_NUM_CH,
   parameter int unsigned RST_PERIOD = DEF_RST_PERIOD
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_en,
   input  logic                    i_mode,
   input  logic [CNT_W-1:0]        i_period,
   input  logic [NUM_CH*CNT_W-1:0] i_duty,
   input  logic                    i_load,
   output logic [CNT_W-1:0]        o_counter,
   output logic                    o_dir,
   output logic [NUM_CH-1:0]       o_pwm,
   output logic                    o_period_tick
);

   localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(RST_PERIOD);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   dir_t             dir_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] act_period_q;
   logic [CNT_W-1:0] shd_period_q;
   logic             act_mode_q;
   logic             shd_mode_q;
   logic             tick_q;
   logic             boundary_c;

   pwm_multi_timer_if #(.CNT_W(CNT_W)) ch_bus ();

   // Boundary: counter is about to return to 0; P = 0 makes every cycle a boundary.
   always_comb begin
      boundary_c = 1'b0;
      if (act_period_q == '0)
         boundary_c = 1'b1;
      else if (act_mode_q == MODE_EDGE)
         boundary_c = (cnt_q >= act_period_q);
      else if (dir_q == DIR_DOWN)
         boundary_c = (cnt_q <= ONE);
      else
         boundary_c = (cnt_q >= act_period_q) && (act_period_q == ONE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q        <= '0;
         dir_q        <= DIR_UP;
         tick_q       <= 1'b0;
         act_period_q <= PERIOD_RST;
         shd_period_q <= PERIOD_RST;
         act_mode_q   <= MODE_EDGE;
         shd_mode_q   <= MODE_EDGE;
      end else begin
         if (i_load) begin
            shd_period_q <= i_period;
            shd_mode_q   <= i_mode;
         end
         tick_q <= i_en && boundary_c;
         if (i_en) begin
            if (boundary_c) begin
               cnt_q        <= '0;
               dir_q        <= DIR_UP;
               act_period_q <= shd_period_q;
               act_mode_q   <= shd_mode_q;
            end else if (dir_q == DIR_DOWN) begin
               cnt_q <= cnt_q - ONE;
            end else if (act_mode_q == MODE_CENTER && cnt_q >= act_period_q) begin
               // Turnaround at the top: P is shown once, then count down from P-1.
               cnt_q <= act_period_q - ONE;
               dir_q <= DIR_DOWN;
            end else begin
               cnt_q <= cnt_q + ONE;
            end
         end
      end
   end

   assign ch_bus.load    = i_load;
   assign ch_bus.commit  = i_en && boundary_c;
   assign ch_bus.counter = cnt_q;

   for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
      pwm_compare_ch #(.CNT_W(CNT_W)) u_ch (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .bus     (ch_bus),
         .duty_in (i_duty[k*CNT_W +: CNT_W]),
         .pwm_c   (o_pwm[k])
      );
   end

   assign o_counter     = cnt_q;
   assign o_dir         = (dir_q == DIR_DOWN);
   assign o_period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi_timer.sv
// Directed self-checking bench for pwm_multi_timer with hand-computed expectations.
module tb_pwm_multi_timer;

   localparam int unsigned CNT_W  = 10;
   localparam int unsigned NUM_CH = 4;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    en;
   logic                    mode;
   logic [CNT_W-1:0]        period;
   logic [NUM_CH*CNT_W-1:0] duty;
   logic                    dir;
   logic [NUM_CH-1:0]       pwm;
   logic                    tick;

   int unsigned errors = 0;
   int unsigned checks = 0;

   pwm_multi_timer_if #(.CNT_W(CNT_W)) bus ();

   pwm_multi_timer #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .RST_PERIOD(999)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_en          (en),
      .i_mode        (mode),
      .i_period      (period),
      .i_duty        (duty),
      .i_load        (bus.load),
      .o_counter     (bus.counter),
      .o_dir         (dir),
      .o_pwm         (pwm),
      .o_period_tick (tick)
   );

   assign bus.commit = tick;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
      duty = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
   endtask

   task automatic load_pulse();
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   task automatic wait_tick(input string tag, input int max_cyc);
      int n = 0;
      do begin
         step();
         n++;
      end while (!tick && n < max_cyc);
      check(tag, 32'(tick), 32'd1);
   endtask

   int exp_cnt[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
   int exp_dir[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
   int exp_p1 [8] = '{1, 1, 0, 0, 0, 0, 0, 1};

   initial begin
      int ticks;
      int highs[4];
      int toggles;
      int n;
      logic prev0;

      reset = 1'b1; en = 1'b0; mode = 1'b0; period = '0; duty = '0; bus.load = 1'b0;
      steps(2);
      check("rst_counter", 32'(bus.counter), 32'd0);
      check("rst_dir",     32'(dir),         32'd0);
      check("rst_tick",    32'(tick),        32'd0);
      check("rst_pwm",     32'(pwm),         32'd0);

      // Default period 999 in edge mode: first tick on the 1000th enabled edge.
      reset = 1'b0; en = 1'b1;
      ticks = 0;
      for (int i = 1; i <= 1000; i++) begin
         step();
         if (tick) ticks++;
         if (i == 999) check("p999_top", 32'(bus.counter), 32'd999);
      end
      check("p999_wrap",  32'(bus.counter), 32'd0);
      check("p999_tick",  32'(tick),        32'd1);
      check("p999_ticks", 32'(ticks),       32'd1);
      step();
      check("p999_after_cnt",  32'(bus.counter), 32'd1);
      check("p999_after_tick", 32'(tick),        32'd0);

      // Edge mode P=9 with duties {0,3,9,10}.
      period = 10'd9; mode = 1'b0; set_duty(0, 3, 9, 10);
      load_pulse();
      wait_tick("edge9_tick", 2000);
      highs = '{0, 0, 0, 0};
      toggles = 0;
      prev0 = pwm[0];
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 4; k++) if (pwm[k]) highs[k]++;
         if (pwm[0] != prev0) toggles++;
         prev0 = pwm[0];
         step();
      end
      check("edge9_high0",   32'(highs[0]), 32'd0);
      check("edge9_high1",   32'(highs[1]), 32'd3);
      check("edge9_high2",   32'(highs[2]), 32'd9);
      check("edge9_high3",   32'(highs[3]), 32'd10);
      check("edge9_tog0",    32'(toggles),  32'd0);
      check("edge9_wrapcnt", 32'(bus.counter), 32'd0);
      check("edge9_wraptk",  32'(tick),     32'd1);

      // Mid-period duty change 3 -> 7 on channel 1.
      steps(2);
      set_duty(0, 7, 9, 10);
      load_pulse();
      check("mid_cnt3",     32'(bus.counter), 32'd3);
      check("mid_old_duty", 32'(pwm[1]),      32'd0);
      steps(6);
      check("mid_cnt9",     32'(bus.counter), 32'd9);
      step();
      check("mid_new_c0",   32'(pwm[1]), 32'd1);
      steps(6);
      check("mid_new_c6",   32'(pwm[1]), 32'd1);
      step();
      check("mid_new_c7",   32'(pwm[1]), 32'd0);
      // Load on the boundary edge: applies one period later.
      steps(2);
      set_duty(0, 2, 9, 10);
      load_pulse();
      check("bnd_tick",     32'(tick), 32'd1);
      steps(5);
      check("bnd_defer_c5", 32'(pwm[1]), 32'd1);
      steps(10);
      check("bnd_apply_c5", 32'(pwm[1]), 32'd0);

      // Enable gating at counter 6 for 5 cycles.
      step();
      check("en_cnt6", 32'(bus.counter), 32'd6);
      en = 1'b0;
      ticks = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (tick) ticks++;
      end
      check("en_frozen",   32'(bus.counter), 32'd6);
      check("en_no_tick",  32'(ticks),       32'd0);
      check("en_pwm_live", 32'(pwm),         32'b1100);
      en = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!tick && n < 20);
      check("en_remaining", 32'(n), 32'd4);

      // Center mode P=4.
      period = 10'd4; mode = 1'b1; set_duty(0, 2, 0, 5);
      load_pulse();
      wait_tick("ctr_tick", 2000);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ctr_cnt%0d", i), 32'(bus.counter), 32'(exp_cnt[i]));
         check($sformatf("ctr_dir%0d", i), 32'(dir),         32'(exp_dir[i]));
         check($sformatf("ctr_p1_%0d", i), 32'(pwm[1]),      32'(exp_p1[i]));
         check($sformatf("ctr_p3_%0d", i), 32'(pwm[3]),      32'd1);
         step();
      end
      check("ctr_wrap_cnt",  32'(bus.counter), 32'd0);
      check("ctr_wrap_tick", 32'(tick),        32'd1);

      // Period 0: counter parked, tick every enabled cycle.
      period = 10'd0; mode = 1'b0;
      load_pulse();
      wait_tick("p0_first", 20);
      steps(3);
      check("p0_cnt",  32'(bus.counter), 32'd0);
      check("p0_tick", 32'(tick),        32'd1);
      check("p0_dir",  32'(dir),         32'd0);
      check("p0_pwm",  32'(pwm),         32'b1010);
      en = 1'b0;
      step();
      check("p0_en_off_tick", 32'(tick), 32'd0);
      en = 1'b1;

      // Reset mid-period at counter 500.
      period = 10'd999; mode = 1'b0; set_duty(600, 700, 100, 5);
      load_pulse();
      wait_tick("rmid_tick", 20);
      steps(500);
      check("rmid_cnt500", 32'(bus.counter), 32'd500);
      check("rmid_pwm",    32'(pwm),         32'b0011);
      reset = 1'b1;
      step();
      check("rmid_cnt0", 32'(bus.counter), 32'd0);
      check("rmid_pwm0", 32'(pwm),         32'd0);
      check("rmid_tick", 32'(tick),        32'd0);
      check("rmid_dir",  32'(dir),         32'd0);
      reset = 1'b0;
      steps(999);
      check("rmid_p999",      32'(bus.counter), 32'd999);
      check("rmid_p999_tick", 32'(tick),        32'd0);
      step();
      check("rmid_wrap",      32'(bus.counter), 32'd0);
      check("rmid_wrap_tick", 32'(tick),        32'd1);
      check("rmid_duty_clr",  32'(pwm),         32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_multi_timer.md
PWM_MULTI_TIMER -- requirements
Module: pwm_multi_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 10, counter and compare width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, number of PWM output channels.
REQ-003 SHALL have parameter RST_PERIOD, default 999, period value loaded at reset.
REQ-004 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port i_en  input  1  count enable.
REQ-007 SHALL have port i_mode  input  1  0 = edge-aligned (up), 1 = center-aligned (up/down).
REQ-008 SHALL have port i_period  input  CNT_W  requested period top value.
REQ-009 SHALL have port i_duty  input  NUM_CH*CNT_W  requested duties, channel k at bits [k*CNT_W +: CNT_W].
REQ-010 SHALL have port i_load  input  1  one-cycle strobe capturing i_duty, i_period and i_mode into shadow registers.
REQ-011 SHALL have port o_counter  output  CNT_W  current counter value.
REQ-012 SHALL have port o_dir  output  1  count direction, 0 = up, 1 = down.
REQ-013 SHALL have port o_pwm  output  NUM_CH  PWM outputs.
REQ-014 SHALL have port o_period_tick  output  1  one-cycle pulse at each period boundary.

Function
REQ-015 Edge mode SHALL count 0..P then wrap to 0, where P is the active period, giving P+1 cycles per period.
REQ-016 Center mode SHALL count up 0..P, then down P-1..0, then up again, giving 2P cycles per period; o_dir SHALL be 1 only while counting down.
REQ-017 Period boundary SHALL be the edge on which the counter becomes 0 from P (edge mode) or from 1 while counting down (center mode).
REQ-018 On each boundary, shadow period, mode and duties SHALL be copied to the active registers; the new values govern the cycle in which o_counter = 0.
REQ-019 i_load SHALL write the shadows on the next edge; if i_load coincides with a boundary, the active registers SHALL take the old shadows and the new values SHALL apply from the following boundary.
REQ-020 o_period_tick SHALL be high exactly in the cycle where o_counter = 0 following a boundary; it SHALL NOT pulse after reset release.
REQ-021 In every cycle o_pwm[k] SHALL equal (o_counter < active duty[k]), with no extra latency.
REQ-022 Duty 0 SHALL give a constant-low output; duty > P SHALL give a constant-high output; there SHALL be no glitch at wrap.
REQ-023 Active P = 0 SHALL hold the counter at 0 with o_period_tick high every enabled cycle and o_dir = 0.
REQ-024 When i_en = 0, counter, o_dir and active registers SHALL hold, o_period_tick SHALL be 0, and o_pwm SHALL keep following REQ-021; i_load SHALL still update shadows.
REQ-025 Arithmetic SHALL be unsigned CNT_W-bit; the counter SHALL never exceed P nor underflow below 0.

Reset
REQ-026 While i_reset = 1 at an edge: counter 0, o_dir 0, o_period_tick 0, active and shadow period = RST_PERIOD, mode = edge, all duties 0 (o_pwm all 0).
REQ-027 Reset asserted mid-period SHALL abort the period immediately, with no boundary, tick or shadow transfer; reset SHALL take priority over i_load and i_en.

Structure
REQ-028 Package pwm_timer_pkg SHALL hold the mode encodings MODE_EDGE = 1'b0 and MODE_CENTER = 1'b1, plus the default CNT_W, NUM_CH and RST_PERIOD constants.
REQ-029 Per-channel shadow/active duty registers and the comparator SHALL be sub-module pwm_compare_ch, instantiated NUM_CH times by generate; the counter and direction FSM SHALL live in the top module.

Verification
REQ-030 Reset, then en = 1, edge, P = 999 -> counter 0..999 wraps; tick every 1000 cycles, first tick at cycle 1000.
REQ-031 Edge, P = 9, duties {0,3,9,10} loaded -> pwm highs per period are 0, 3, 9 and 10 (constant high) cycles; ch0 never toggles.
REQ-032 Center, P = 4 -> counter 0,1,2,3,4,3,2,1,0; o_dir high on 3,2,1; duty 2 is high on counter 0,1 in both halves; tick every 8 cycles.
REQ-033 Duty 3 -> 7 load mid-period at P = 9 -> old duty holds to end of period; the new duty is visible starting at counter 0; load on the boundary cycle is deferred one period.
REQ-034 Deassert i_en for 5 cycles at counter 6 -> counter frozen at 6, no tick, period extended by exactly 5 cycles.
REQ-035 Assert i_reset at counter 500 with duties nonzero -> next cycle counter 0, all pwm 0, P = RST_PERIOD, no tick.
